frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter IMG_W, default 100, pixels per row.
REQ-002 Parameter IMG_H, default 100, rows per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, entries in the input elastic buffer; power of two.
REQ-004 gen_clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins frame write-back.
REQ-007 pix_valid  input  1  processed pixel present on pix_in.
REQ-008 pix_in  input  24  processed RGB pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-009 pix_ready  output  1  block accepts pix_in this cycle.
REQ-010 wr_en  output  1  write request to frame memory.
REQ-011 wr_gnt  input  1  memory accepts the write this cycle.
REQ-012 wr_addr  output  14  linear pixel address, 0 to IMG_W*IMG_H-1.
REQ-013 wr_data  output  24  pixel to write.
REQ-014 busy  output  1  high in RUN state.
REQ-015 done  output  1  one-cycle pulse after last pixel write is granted.
REQ-016 err  output  1  sticky protocol error flag.

Function
REQ-017 The block SHALL implement states IDLE, RUN, DONE; busy = (state==RUN).
REQ-018 IDLE: start -> RUN, clearing in_cnt, out_cnt, wr_addr and FIFO; other inputs ignored except for err.
REQ-019 RUN: the state SHALL go to DONE in the cycle after the write that makes out_cnt reach IMG_W*IMG_H is granted.
REQ-020 DONE: done=1 for exactly that one cycle; next state IDLE unconditionally.
REQ-021 start asserted in RUN or DONE SHALL be ignored.
REQ-022 pix_ready = RUN and FIFO not full and in_cnt < IMG_W*IMG_H; combinational from registers only, not from pix_valid.
REQ-023 Push occurs when pix_valid and pix_ready; pix_in is written at tail; in_cnt increments by 1.
REQ-024 wr_en = RUN and FIFO not empty; wr_data = FIFO head; both driven from registers, no dependence on wr_gnt.
REQ-025 Pop occurs when wr_en and wr_gnt; wr_addr and out_cnt increment by 1 in the same edge.
REQ-026 While wr_en=1 and wr_gnt=0, wr_en, wr_addr and wr_data SHALL hold stable.
REQ-027 Simultaneous push and pop SHALL leave FIFO occupancy unchanged; both succeed.
REQ-028 Push into empty FIFO: wr_en rises the following cycle (latency 1 from accepted pixel to write request).
REQ-029 FIFO full: pix_ready=0, even if a pop happens that cycle (no full-bypass).
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-031 wr_addr SHALL never exceed IMG_W*IMG_H-1 while wr_en=1; it returns to 0 on next start.
REQ-032 Pixels SHALL be written in arrival order, raster order, no reordering or dropping.
REQ-033 err SHALL set when pix_valid=1 while state is IDLE or DONE, and stays set until rst.
REQ-034 Throughput: with wr_gnt held 1 and pix_valid held 1, one pixel per cycle sustained.

Reset
REQ-035 On rst: state=IDLE, FIFO empty, pointers/in_cnt/out_cnt=0, wr_addr=0, pix_ready=0, wr_en=0, wr_data=24'h000000, busy=0, done=0, err=0.
REQ-036 rst SHALL take priority over start, push and pop in the same cycle.
REQ-037 rst mid-frame SHALL discard FIFO contents and abort with no done pulse.

Verification
REQ-038 start, pix_valid=1 continuously with pix_in=address index, wr_gnt=1 -> 10000 writes, wr_addr 0..9999 with wr_data==wr_addr, done pulse 1 cycle after write 9999, then IDLE.
REQ-039 wr_gnt=0 for 10 cycles after start with pixels offered -> exactly 4 accepted, pix_ready=0, wr_en=1 stable at wr_addr=0; wr_gnt=1 -> drains in order.
REQ-040 Random pix_valid and wr_gnt (50%) over full frame -> scoreboard match, 10000 writes, no extra accept past pixel 9999 (pix_ready=0).
REQ-041 rst asserted at out_cnt=5000 -> all outputs at reset values next cycle, no done; new start rewrites from wr_addr=0.
REQ-042 pix_valid=1 in IDLE -> err=1 sticky, no write; start during RUN -> no counter change.

Source files
------------

// File: rtl/frame_writer_if.sv
// Pixel-in / memory-write / status bundle for frame_writer.
// The master side is the pixel source and the memory; the slave side is the writer.
interface frame_writer_if;
    logic        start;
    logic        pix_valid;
    logic [23:0] pix_in;
    logic        pix_ready;
    logic        wr_en;
    logic        wr_gnt;
    logic [13:0] wr_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, pix_valid, pix_in, wr_gnt,
        input  pix_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, pix_valid, pix_in, wr_gnt,
        output pix_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/frame_writer.sv
// Buffers processed pixels in a small elastic FIFO and writes one full frame
// to memory in raster order, one pixel per granted write.
module frame_writer #(
    parameter int unsigned IMG_W      = 100,
    parameter int unsigned IMG_H      = 100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          gen_clk,
    input  logic          rst,
    frame_writer_if.slave bus
);
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned CNT_W  = $clog2(NPIX + 1);
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [23:0]        r_mem [FIFO_DEPTH];
    logic               r_err;

    logic w_run;
    logic w_full;
    logic w_empty;
    logic w_pix_ready;
    logic w_wr_en;
    logic w_push;
    logic w_pop;
    logic w_last_pop;
    logic w_clear;
    logic w_busy;
    logic w_done;

    assign w_run       = (r_state == S_RUN);
    assign w_full      = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_empty     = (r_occ == '0);
    assign w_pix_ready = w_run && !w_full && (r_in_cnt < CNT_W'(NPIX));
    assign w_wr_en     = w_run && !w_empty;
    assign w_push      = bus.pix_valid && w_pix_ready;
    assign w_pop       = w_wr_en && bus.wr_gnt;
    assign w_last_pop  = w_pop && (r_out_cnt == CNT_W'(NPIX - 1));
    assign w_clear     = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge gen_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_pop) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Pointers and counters; a new start discards anything left from before.
    always_ff @(posedge gen_clk) begin
        if (rst || w_clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
            else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge gen_clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.pix_in;
        end
    end

    always_ff @(posedge gen_clk) begin
        if (rst)                                      r_err <= 1'b0;
        else if (bus.pix_valid && r_state != S_RUN)   r_err <= 1'b1;
    end

    assign bus.pix_ready = w_pix_ready;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr   = ADDR_W'(r_out_cnt);
    assign bus.wr_data   = r_mem[r_rd_ptr];
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: accepted pixels are queued with their
// expected raster address and checked against each memory write request.
module tb_frame_writer;
    localparam int NPIX = 10000;

    typedef struct packed {
        logic [13:0] addr;
        logic [23:0] data;
    } exp_t;

    logic gen_clk = 1'b0;
    logic rst;
    frame_writer_if bus();

    frame_writer #(.IMG_W(100), .IMG_H(100), .FIFO_DEPTH(4)) dut (
        .gen_clk (gen_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 gen_clk = ~gen_clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    task automatic step();
        @(posedge gen_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = '0; bus.wr_gnt = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.pix_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pix_ready got=%b want=0", bus.pix_ready); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 14'd0) begin n_bad++; $display("FAIL reset_wr_addr got=%0d want=0", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 24'h0) begin n_bad++; $display("FAIL reset_wr_data got=%h want=000000", bus.wr_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_frame();
        int in_idx = 0;
        int writes = 0;
        int last_wr = -1;
        int done_at = -1;
        exp_t e;
        sb.delete();
        bus.wr_gnt = 1'b1;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int cyc = 0; cyc < 12000 && done_at < 0; cyc++) begin
            bus.pix_valid = bus.busy;
            bus.pix_in    = 24'(in_idx);
            @(negedge gen_clk);
            if (bus.done) done_at = cyc;
            if (bus.pix_valid && in_idx >= NPIX) begin
                n_cmp++;
                if (bus.pix_ready !== 1'b0) begin n_bad++; $display("FAIL full_extra_accept pix_ready=%b want=0", bus.pix_ready); end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                e.addr = 14'(in_idx); e.data = 24'(in_idx); sb.push_back(e); in_idx++;
            end
            if (bus.wr_en) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL full_spurious_write addr=%0d with no pixel pending", bus.wr_addr);
                end else begin
                    e = sb[0];
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                        n_bad++; $display("FAIL full_write got addr=%0d data=%h want addr=%0d data=%h", bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                    if (bus.wr_gnt) begin void'(sb.pop_front()); writes++; last_wr = cyc; end
                end
            end
            step();
        end
        n_cmp++; if (done_at < 0) begin n_bad++; $display("FAIL full_done_timeout done never seen, writes=%0d want %0d", writes, NPIX); end
        n_cmp++; if (done_at != last_wr + 1) begin n_bad++; $display("FAIL full_done_latency done_cycle=%0d want %0d", done_at, last_wr + 1); end
        n_cmp++; if (writes != NPIX) begin n_bad++; $display("FAIL full_write_count got=%0d want=%0d", writes, NPIX); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL full_leftover got=%0d pending want=0", sb.size()); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL full_back_to_idle busy=%b done=%b want 0/0", bus.busy, bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL full_err got=%b want=0", bus.err); end
    endtask

    task automatic test_backpressure();
        int in_idx = 0;
        int writes = 0;
        exp_t e;
        sb.delete();
        bus.wr_gnt = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.pix_valid = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc == 10) begin
                n_cmp++; if (in_idx != 4) begin n_bad++; $display("FAIL bp_accepted got=%0d want=4", in_idx); end
                n_cmp++; if (bus.pix_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pix_ready got=%b want=0", bus.pix_ready); end
                n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 14'd0) begin n_bad++; $display("FAIL bp_hold wr_en=%b addr=%0d want 1/0", bus.wr_en, bus.wr_addr); end
                bus.wr_gnt = 1'b1;
            end
            bus.pix_valid = (in_idx < 12);
            bus.pix_in    = 24'hA00000 | 24'(in_idx);
            @(negedge gen_clk);
            if (bus.pix_valid && bus.pix_ready) begin
                e.addr = 14'(in_idx); e.data = 24'hA00000 | 24'(in_idx); sb.push_back(e); in_idx++;
            end
            if (bus.wr_en) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL bp_spurious_write addr=%0d", bus.wr_addr);
                end else begin
                    e = sb[0];
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                        n_bad++; $display("FAIL bp_write got addr=%0d data=%h want addr=%0d data=%h", bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                    if (bus.wr_gnt) begin void'(sb.pop_front()); writes++; end
                end
            end
            step();
        end
        n_cmp++; if (writes != 12 || sb.size() != 0) begin n_bad++; $display("FAIL bp_drain writes=%0d pending=%0d want 12/0", writes, sb.size()); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL bp_idle_wr_en got=%b want=0", bus.wr_en); end
        bus.pix_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
    endtask

    task automatic test_random();
        int in_idx = 0;
        int writes = 0;
        bit done_seen = 1'b0;
        exp_t e;
        sb.delete();
        bus.wr_gnt = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int cyc = 0; cyc < 45000 && !done_seen; cyc++) begin
            bus.pix_valid = bus.busy && ($urandom_range(0, 1) == 1);
            bus.pix_in    = 24'($urandom);
            bus.wr_gnt    = ($urandom_range(0, 1) == 1);
            @(negedge gen_clk);
            if (bus.done) done_seen = 1'b1;
            if (bus.pix_valid && in_idx >= NPIX) begin
                n_cmp++;
                if (bus.pix_ready !== 1'b0) begin n_bad++; $display("FAIL rnd_extra_accept pix_ready=%b want=0", bus.pix_ready); end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                e.addr = 14'(in_idx); e.data = bus.pix_in; sb.push_back(e); in_idx++;
            end
            if (bus.wr_en) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL rnd_spurious_write addr=%0d", bus.wr_addr);
                end else begin
                    e = sb[0];
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                        n_bad++; $display("FAIL rnd_write got addr=%0d data=%h want addr=%0d data=%h", bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                    if (bus.wr_gnt) begin void'(sb.pop_front()); writes++; end
                end
            end
            step();
        end
        bus.pix_valid = 1'b0;
        n_cmp++; if (!done_seen) begin n_bad++; $display("FAIL rnd_done_timeout writes=%0d want %0d", writes, NPIX); end
        n_cmp++; if (writes != NPIX || in_idx != NPIX) begin n_bad++; $display("FAIL rnd_counts writes=%0d accepted=%0d want %0d", writes, in_idx, NPIX); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rnd_err got=%b want=0", bus.err); end
    endtask

    task automatic test_mid_reset();
        int in_idx = 0;
        int writes = 0;
        exp_t e;
        sb.delete();
        bus.wr_gnt = 1'b1;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int cyc = 0; cyc < 6000 && writes < 5000; cyc++) begin
            bus.pix_valid = bus.busy;
            bus.pix_in    = 24'h5A0000 ^ 24'(in_idx);
            @(negedge gen_clk);
            if (bus.pix_valid && bus.pix_ready) begin
                e.addr = 14'(in_idx); e.data = 24'h5A0000 ^ 24'(in_idx); sb.push_back(e); in_idx++;
            end
            if (bus.wr_en && bus.wr_gnt && sb.size() != 0) begin void'(sb.pop_front()); writes++; end
            step();
        end
        n_cmp++; if (writes != 5000) begin n_bad++; $display("FAIL mid_reach_5000 writes=%0d want 5000", writes); end
        rst = 1'b1; bus.pix_valid = 1'b0; bus.wr_gnt = 1'b0;
        step();
        n_cmp++; if (bus.pix_ready !== 1'b0 || bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_handshake pix_ready=%b wr_en=%b want 0/0", bus.pix_ready, bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 14'd0 || bus.wr_data !== 24'h0) begin n_bad++; $display("FAIL mid_rst_bus addr=%0d data=%h want 0/000000", bus.wr_addr, bus.wr_data); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_status busy=%b done=%b err=%b want 0/0/0", bus.busy, bus.done, bus.err); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_no_done done=%b busy=%b want 0/0", bus.done, bus.busy); end
        end
        sb.delete(); in_idx = 0; writes = 0;
        bus.wr_gnt = 1'b1;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.pix_valid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.pix_in = 24'h330000 | 24'(in_idx);
            @(negedge gen_clk);
            if (bus.pix_valid && bus.pix_ready) begin
                e.addr = 14'(in_idx); e.data = 24'h330000 | 24'(in_idx); sb.push_back(e); in_idx++;
            end
            if (bus.wr_en) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL mid_restart_spurious addr=%0d", bus.wr_addr);
                end else begin
                    e = sb[0];
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                        n_bad++; $display("FAIL mid_restart_write got addr=%0d data=%h want addr=%0d data=%h", bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                    if (bus.wr_gnt) begin void'(sb.pop_front()); writes++; end
                end
            end
            step();
        end
        n_cmp++; if (writes != 9) begin n_bad++; $display("FAIL mid_restart_rate writes=%0d want 9", writes); end
        bus.pix_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
    endtask

    task automatic test_err_and_start();
        bus.wr_gnt = 1'b1; bus.pix_valid = 1'b1; bus.pix_in = 24'h123456;
        for (int k = 0; k < 2; k++) begin
            @(negedge gen_clk);
            n_cmp++; if (bus.wr_en !== 1'b0 || bus.pix_ready !== 1'b0) begin n_bad++; $display("FAIL err_idle_nowrite wr_en=%b pix_ready=%b want 0/0", bus.wr_en, bus.pix_ready); end
            step();
        end
        bus.pix_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
            step();
        end
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.pix_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.pix_in = 24'hC00000 | 24'(k);
            step();
        end
        bus.pix_valid = 1'b0; bus.wr_gnt = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 14'd2 || bus.wr_data !== 24'hC00002) begin n_bad++; $display("FAIL run_pending wr_en=%b addr=%0d data=%h want 1/2/c00002", bus.wr_en, bus.wr_addr, bus.wr_data); end
        bus.start = 1'b1; step(); bus.start = 1'b0; step();
        n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 14'd2 || bus.wr_data !== 24'hC00002) begin n_bad++; $display("FAIL start_in_run wr_en=%b addr=%0d data=%h want 1/2/c00002", bus.wr_en, bus.wr_addr, bus.wr_data); end
        n_cmp++; if (bus.busy !== 1'b1 || bus.pix_ready !== 1'b1) begin n_bad++; $display("FAIL start_in_run_state busy=%b pix_ready=%b want 1/1", bus.busy, bus.pix_ready); end
        bus.wr_gnt = 1'b1; step(); bus.wr_gnt = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 14'd3) begin n_bad++; $display("FAIL run_drained wr_en=%b addr=%0d want 0/3", bus.wr_en, bus.wr_addr); end
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_still_set got=%b want=1", bus.err); end
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL err_cleared err=%b busy=%b want 0/0", bus.err, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_err_and_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
